mem_access: RTL and testbench

Memory-access stage of the core pipeline, directly downstream of `execution`. It captures the execute-stage results and performs the following in its stage cycle:
- data-memory reads and writes;
- UART receive/transmit with handshake and pipeline stall;
- branch resolution with wrong-path squash;
- presentation of write-back data and control to the register file.

---
 rtl/mem_access.sv | 115 +++++++++++
 tb/tb_mem_access.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage with data RAM issue, UART handshake stall, branch resolve/squash and write-back
module mem_access #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 10
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  output logic                      stall,
  output logic                      dmem_en,
  output logic                      dmem_we,
  output logic [DATA_MEM_WIDTH-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic [7:0]                uart_rx_data,
  input  logic                      uart_rx_valid,
  output logic                      uart_rx_ready,
  output logic [7:0]                uart_tx_data,
  output logic                      uart_tx_valid,
  input  logic                      uart_tx_ready,
  output logic                      branch_taken,
  output logic [INST_MEM_WIDTH-1:0] branch_target,
  output logic                      RegWrite_wb,
  output logic                      distinct_wb,
  output logic [4:0]                rdist_wb,
  output logic [31:0]               wb_data
);
  typedef struct packed {
    logic                      distinct;
    logic                      reg_write;
    logic                      mem_write;
    logic                      mem_read;
    logic                      uart_to_reg;
    logic                      reg_to_uart;
    logic [1:0]                mem_to_reg;
    logic [1:0]                branch;
    logic [31:0]               register_data;
    logic [31:0]               alu_result;
    logic [4:0]                rdist;
    logic [25:0]               inst_index;
    logic [INST_MEM_WIDTH-1:0] pc1;
    logic [INST_MEM_WIDTH-1:0] pc2;
  } stage_t;
  typedef enum logic [1:0] {RUN, WAIT_RX, WAIT_TX} state_t;
  state_t     state_q, state_d;
  stage_t     s_q, s_d, live, bubble;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       unused_s;
  assign live = {distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, MemtoReg, Branch,
                 register_data, alu_result, rdist, inst_index, pc1, pc2};
  always_comb begin
    bubble = '0;
    bubble.branch = 2'b11;
  end
  assign stall = state_q != RUN;
  assign branch_taken = ~stall & (s_q.branch == 2'b00 ? s_q.alu_result == 32'd0 :
                                  s_q.branch == 2'b01 ? s_q.alu_result != 32'd0 :
                                  s_q.branch == 2'b10);
  assign branch_target = ~branch_taken ? '0 :
                         s_q.branch == 2'b10 ? s_q.inst_index[INST_MEM_WIDTH-1:0] : s_q.pc2;
  // Memory is issued from the live inputs so read data lands while the instruction sits in S.
  assign dmem_en = (MemRead | MemWrite) & ~stall & ~branch_taken & ~reset;
  assign dmem_we = MemWrite & ~stall & ~branch_taken & ~reset;
  assign dmem_addr = alu_result[DATA_MEM_WIDTH-1:0];
  assign dmem_wdata = register_data;
  assign uart_rx_ready = state_q == WAIT_RX;
  assign uart_tx_valid = state_q == WAIT_TX;
  assign uart_tx_data = uart_tx_valid ? s_q.register_data[7:0] : 8'd0;
  assign RegWrite_wb = s_q.reg_write & ~stall;
  assign distinct_wb = s_q.distinct;
  assign rdist_wb = s_q.rdist;
  assign wb_data = s_q.uart_to_reg ? {24'd0, rx_byte_q} :
                   s_q.mem_to_reg == 2'b00 ? s_q.alu_result :
                   s_q.mem_to_reg == 2'b01 ? dmem_rdata :
                   s_q.mem_to_reg == 2'b10 ? {{(32-INST_MEM_WIDTH){1'b0}}, s_q.pc1} : 32'd0;
  assign unused_s = ^{s_q.mem_write, s_q.mem_read, s_q.reg_to_uart, s_q.register_data[31:8],
                      s_q.inst_index[25:INST_MEM_WIDTH]};
  always_comb begin
    s_d = stall ? s_q : branch_taken ? bubble : live;
    rx_byte_d = (state_q == WAIT_RX && uart_rx_valid) ? uart_rx_data : rx_byte_q;
    state_d = state_q;
    if (state_q == RUN)
      state_d = branch_taken ? RUN : UARTtoReg ? WAIT_RX : RegtoUART ? WAIT_TX : RUN;
    else if (state_q == WAIT_RX)
      state_d = uart_rx_valid ? RUN : WAIT_RX;
    else if (state_q == WAIT_TX)
      state_d = uart_tx_ready ? RUN : WAIT_TX;
    else
      state_d = RUN;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      s_q <= bubble;
      state_q <= RUN;
      rx_byte_q <= 8'd0;
    end else begin
      s_q <= s_d;
      state_q <= state_d;
      rx_byte_q <= rx_byte_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access against an instruction-level reference model
module tb_mem_access;
  localparam int IW = 2;
  localparam int DW = 10;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART;
  logic [1:0] MemtoReg, Branch;
  logic [31:0] register_data, alu_result;
  logic [4:0] rdist;
  logic [25:0] inst_index;
  logic [IW-1:0] pc1, pc2;
  logic stall, dmem_en, dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [7:0] uart_rx_data, uart_tx_data;
  logic uart_rx_valid = 1'b0, uart_rx_ready, uart_tx_valid, uart_tx_ready = 1'b0;
  logic branch_taken, RegWrite_wb, distinct_wb;
  logic [IW-1:0] branch_target;
  logic [4:0] rdist_wb;
  logic [31:0] wb_data;

  always #5 CLK = ~CLK;

  mem_access #(.INST_MEM_WIDTH(IW), .DATA_MEM_WIDTH(DW)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART), .MemtoReg(MemtoReg),
    .Branch(Branch), .register_data(register_data), .alu_result(alu_result), .rdist(rdist),
    .inst_index(inst_index), .pc1(pc1), .pc2(pc2), .stall(stall), .dmem_en(dmem_en),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .RegWrite_wb(RegWrite_wb),
    .distinct_wb(distinct_wb), .rdist_wb(rdist_wb), .wb_data(wb_data)
  );

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];
  always @(posedge CLK) begin
    if (dmem_en) begin
      if (dmem_we) ram[dmem_addr] <= dmem_wdata;
      dmem_rdata <= ram[dmem_addr];
    end
  end

  typedef struct {
    logic distinct, rw, mw, mr, u2r, r2u;
    logic [1:0] m2r, br;
    logic [31:0] rd, alu;
    logic [4:0] rdist;
    logic [25:0] idx;
    logic [IW-1:0] pc1, pc2;
    int d;
    logic [7:0] rx;
  } ins_t;

  logic [37:0] wb_q [$];
  logic [IW-1:0] br_q [$];
  logic [41:0] st_q [$];
  logic [7:0] tx_q [$];
  int stall_q [$];
  int n_cmp = 0, n_err = 0, scnt = 0;
  bit last_taken = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT produced an output with nothing expected", nm);
  endtask

  function automatic ins_t nop();
    ins_t i;
    i.distinct = 0; i.rw = 0; i.mw = 0; i.mr = 0; i.u2r = 0; i.r2u = 0;
    i.m2r = 2'b00; i.br = 2'b11; i.rd = 0; i.alu = 0; i.rdist = 0; i.idx = 0;
    i.pc1 = 0; i.pc2 = 0; i.d = 0; i.rx = 0;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i = nop();
    i.distinct = 1'($urandom); i.rd = $urandom; i.alu = $urandom; i.rdist = 5'($urandom);
    i.idx = 26'($urandom); i.pc1 = IW'($urandom); i.pc2 = IW'($urandom);
    i.d = $urandom_range(0, 3); i.rx = 8'($urandom);
    case ($urandom_range(0, 7))
      0: begin i.rw = 1; i.m2r = $urandom_range(0, 1) ? 2'b00 : 2'b11; end
      1: begin i.mr = 1; i.rw = 1; i.m2r = 2'b01; i.alu[9:0] = 10'($urandom_range(0, 15)); end
      2: begin i.mw = 1; i.alu[9:0] = 10'($urandom_range(0, 15)); end
      3: begin i.br = 2'($urandom_range(0, 1)); if ($urandom_range(0, 1) == 1) i.alu = 0; end
      4: begin i.br = 2'b10; i.rw = 1; i.m2r = 2'b10; end
      5: begin i.u2r = 1; i.rw = 1; end
      6: i.r2u = 1;
      default: ;
    endcase
    return i;
  endfunction

  task automatic apply(input ins_t i);
    distinct = i.distinct; RegWrite = i.rw; MemWrite = i.mw; MemRead = i.mr;
    UARTtoReg = i.u2r; RegtoUART = i.r2u; MemtoReg = i.m2r; Branch = i.br;
    register_data = i.rd; alu_result = i.alu; rdist = i.rdist; inst_index = i.idx;
    pc1 = i.pc1; pc2 = i.pc2;
  endtask

  // Instruction-level semantics: what each retired instruction must make visible.
  task automatic model(input ins_t i);
    logic [31:0] v;
    bit taken;
    if (last_taken) begin
      last_taken = 0;
      return;
    end
    if (i.mw) begin
      ref_mem[i.alu[9:0]] = i.rd;
      st_q.push_back({i.alu[9:0], i.rd});
    end
    if (i.rw) begin
      if (i.u2r) v = {24'd0, i.rx};
      else if (i.m2r == 2'b00) v = i.alu;
      else if (i.m2r == 2'b01) v = ref_mem[i.alu[9:0]];
      else if (i.m2r == 2'b10) v = 32'(i.pc1);
      else v = 0;
      wb_q.push_back({i.distinct, i.rdist, v});
    end
    if (i.u2r) stall_q.push_back(i.d + 1);
    else if (i.r2u) begin
      tx_q.push_back(i.rd[7:0]);
      stall_q.push_back(i.d + 1);
    end
    taken = (i.br == 2'b00 && i.alu == 0) || (i.br == 2'b01 && i.alu != 0) || i.br == 2'b10;
    if (taken) br_q.push_back(i.br == 2'b10 ? i.idx[IW-1:0] : i.pc2);
    last_taken = taken;
  endtask

  task automatic issue(input ins_t i);
    bit sq = last_taken;
    model(i);
    apply(i);
    @(posedge CLK);
    #1;
    if (!sq && i.u2r) begin
      repeat (i.d) @(posedge CLK);
      #1;
      uart_rx_valid = 1; uart_rx_data = i.rx;
      @(posedge CLK);
      #1;
      uart_rx_valid = 0;
    end else if (!sq && i.r2u) begin
      repeat (i.d) @(posedge CLK);
      #1;
      uart_tx_ready = 1;
      @(posedge CLK);
      #1;
      uart_tx_ready = 0;
    end
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      if (RegWrite_wb) begin
        if (wb_q.size() == 0) unexp("writeback");
        else chk("writeback", 64'({distinct_wb, rdist_wb, wb_data}), 64'(wb_q.pop_front()));
      end
      if (branch_taken) begin
        if (br_q.size() == 0) unexp("branch");
        else chk("branch_target", 64'(branch_target), 64'(br_q.pop_front()));
      end else chk("idle_target", 64'(branch_target), 64'd0);
      if (dmem_we) begin
        if (st_q.size() == 0) unexp("store");
        else chk("store", 64'({dmem_addr, dmem_wdata}), 64'(st_q.pop_front()));
      end
      if (uart_tx_valid) begin
        if (tx_q.size() == 0) unexp("tx");
        else begin
          chk("tx_data", 64'(uart_tx_data), 64'(tx_q[0]));
          if (uart_tx_ready) void'(tx_q.pop_front());
        end
      end
      if (stall) scnt++;
      else if (scnt > 0) begin
        if (stall_q.size() == 0) unexp("stall");
        else chk("stall_len", 64'(scnt), 64'(stall_q.pop_front()));
        scnt = 0;
      end
    end
  end

  initial begin
    ins_t i;
    for (int k = 0; k < 1024; k++) begin
      ram[k] = $urandom;
      ref_mem[k] = ram[k];
    end
    apply(rnd());
    uart_rx_valid = 1; uart_tx_ready = 1; uart_rx_data = 8'($urandom);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_dmem_en", 64'(dmem_en), 0);
    chk("rst_dmem_we", 64'(dmem_we), 0);
    chk("rst_rx_ready", 64'(uart_rx_ready), 0);
    chk("rst_tx_valid", 64'(uart_tx_valid), 0);
    chk("rst_branch", 64'(branch_taken), 0);
    chk("rst_regwrite", 64'(RegWrite_wb), 0);
    chk("rst_wb_data", 64'(wb_data), 0);
    @(posedge CLK);
    #1;
    reset = 0; uart_rx_valid = 0; uart_tx_ready = 0;
    i = nop(); i.mw = 1; i.alu = 5; i.rd = 32'hDEADBEEF; issue(i);
    i = nop(); i.mr = 1; i.rw = 1; i.m2r = 2'b01; i.alu = 5; i.rdist = 7; issue(i);
    i = nop(); i.u2r = 1; i.rw = 1; i.rx = 8'h41; i.d = 3; i.rdist = 3; issue(i);
    i = nop(); i.r2u = 1; i.rd = 32'h1234_5678; i.d = 2; issue(i);
    i = nop(); i.br = 2'b00; i.alu = 0; i.pc2 = 3; issue(i);
    i = nop(); i.mw = 1; i.alu = 9; i.rd = 32'hBAD0BAD0; issue(i);
    for (int n = 0; n < 300; n++) issue(rnd());
    repeat (3) issue(nop());
    i = nop(); i.u2r = 1; i.rw = 1; i.rdist = 9;
    apply(i);
    stall_q.push_back(1);
    @(posedge CLK);
    @(negedge CLK);
    chk("wait_rx_stall", 64'(stall), 1);
    chk("wait_rx_ready", 64'(uart_rx_ready), 1);
    @(posedge CLK);
    #1;
    reset = 1;
    apply(nop());
    @(posedge CLK);
    #1;
    reset = 0;
    uart_rx_valid = 1; uart_rx_data = 8'h99;
    repeat (2) begin
      @(negedge CLK);
      chk("abort_stall", 64'(stall), 0);
      chk("abort_rx_ready", 64'(uart_rx_ready), 0);
      chk("abort_regwrite", 64'(RegWrite_wb), 0);
    end
    @(posedge CLK);
    #1;
    uart_rx_valid = 0;
    repeat (3) issue(nop());
    @(negedge CLK);
    chk("wb_left", 64'(wb_q.size()), 0);
    chk("br_left", 64'(br_q.size()), 0);
    chk("st_left", 64'(st_q.size()), 0);
    chk("tx_left", 64'(tx_q.size()), 0);
    chk("stall_left", 64'(stall_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
